// File: rtl/write_fifo_ctrl_if.sv
// Write-side FIFO control bus: producer request, read-pointer input and write-side status/pointers.
`timescale 1ns/1ps
`default_nettype none

interface write_fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  w_request_in;
  logic [ADDR_WIDTH-1:0] r_ptr_gray_in;
  logic [ADDR_WIDTH-1:0] w_ptr_out;
  logic [ADDR_WIDTH-1:0] w_ptr_gray_out;
  logic                  w_en_out;
  logic                  ctrl_full_out;
  logic                  ctrl_almost_full_out;
  logic                  ctrl_overflow_out;

  // Controller side
  modport slave (
    input  w_request_in,
    input  r_ptr_gray_in,
    output w_ptr_out,
    output w_ptr_gray_out,
    output w_en_out,
    output ctrl_full_out,
    output ctrl_almost_full_out,
    output ctrl_overflow_out
  );

  // Producer / environment side
  modport master (
    output w_request_in,
    output r_ptr_gray_in,
    input  w_ptr_out,
    input  w_ptr_gray_out,
    input  w_en_out,
    input  ctrl_full_out,
    input  ctrl_almost_full_out,
    input  ctrl_overflow_out
  );
endinterface

`default_nettype wire

// File: rtl/write_fifo_ctrl.sv
// Async FIFO write-side controller: read-pointer sync, write pointers, full/overflow flags.
// Optional registered almost-full flag enabled by macro W_CTRL_ALMOST_FULL_EN.
`timescale 1ns/1ps
`default_nettype none

module write_fifo_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6
) (
  input  wire logic        w_clk_in,
  input  wire logic        w_reset_n_in,
  write_fifo_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    NOT_FULL = 1'b0,
    FULL     = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] sync_stage1;
  logic [ADDR_WIDTH-1:0] sync_stage2;
  logic [ADDR_WIDTH-1:0] r_ptr_sync;
  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0] w_ptr_gray;
  logic [ADDR_WIDTH-1:0] w_ptr_nxt;
  logic [ADDR_WIDTH-1:0] w_ptr_nxt_plus1;
  logic                  w_en;
  logic                  overflow;
  logic                  almost_full;

  if (AF_LEVEL < 1 || AF_LEVEL >= 2**ADDR_WIDTH) begin : g_af_level_invalid
    $error("write_fifo_ctrl: AF_LEVEL must lie in 1 .. 2**ADDR_WIDTH-1");
  end

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    r_ptr_sync = '0;
    r_ptr_sync[ADDR_WIDTH-1] = sync_stage2[ADDR_WIDTH-1];
    for (int i = ADDR_WIDTH-2; i >= 0; i--) begin
      r_ptr_sync[i] = r_ptr_sync[i+1] ^ sync_stage2[i];
    end
  end

  // Gating with reset keeps the memory write enable low during async reset.
  assign w_en            = bus.w_request_in && (state == NOT_FULL) && w_reset_n_in;
  assign w_ptr_nxt       = w_ptr + ADDR_WIDTH'(w_en);
  assign w_ptr_nxt_plus1 = w_ptr_nxt + ADDR_WIDTH'(1);

  // Full is judged on the post-write pointer so the filling write raises it on its own edge.
  always_comb begin
    state_nxt = state;
    case (state)
      NOT_FULL: begin
        if (bus.w_request_in && (w_ptr_nxt_plus1 == r_ptr_sync)) begin
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (w_ptr_nxt_plus1 != r_ptr_sync) begin
          state_nxt = NOT_FULL;
        end
      end
      default: state_nxt = NOT_FULL;
    endcase
  end

  always_ff @(posedge w_clk_in or negedge w_reset_n_in) begin
    if (!w_reset_n_in) begin
      sync_stage1 <= '0;
      sync_stage2 <= '0;
      w_ptr       <= '0;
      w_ptr_gray  <= '0;
      state       <= NOT_FULL;
      overflow    <= 1'b0;
    end else begin
      sync_stage1 <= bus.r_ptr_gray_in;
      sync_stage2 <= sync_stage1;
      w_ptr       <= w_ptr_nxt;
      w_ptr_gray  <= w_ptr_nxt ^ (w_ptr_nxt >> 1);
      state       <= state_nxt;
      if (bus.w_request_in && (state == FULL)) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef W_CTRL_ALMOST_FULL_EN
  localparam logic [ADDR_WIDTH:0] AF_THRESH = (ADDR_WIDTH+1)'(AF_LEVEL);

  logic [ADDR_WIDTH-1:0] occupancy;

  assign occupancy = w_ptr - r_ptr_sync;

  always_ff @(posedge w_clk_in or negedge w_reset_n_in) begin
    if (!w_reset_n_in) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= ({1'b0, occupancy} >= AF_THRESH);
    end
  end
`else
  assign almost_full = 1'b0;
`endif

  assign bus.w_ptr_out            = w_ptr;
  assign bus.w_ptr_gray_out       = w_ptr_gray;
  assign bus.w_en_out             = w_en;
  assign bus.ctrl_full_out        = (state == FULL);
  assign bus.ctrl_almost_full_out = almost_full;
  assign bus.ctrl_overflow_out    = overflow;

endmodule

`default_nettype wire

// File: tb/tb_write_fifo_ctrl.sv
// Directed self-checking bench for write_fifo_ctrl (ADDR_WIDTH=3, AF_LEVEL=6).
`timescale 1ns/1ps
`default_nettype none

module tb_write_fifo_ctrl;

  localparam int ADDR_WIDTH = 3;
  localparam int AF_LEVEL   = 6;
`ifdef W_CTRL_ALMOST_FULL_EN
  localparam logic AF_EN = 1'b1;
`else
  localparam logic AF_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  write_fifo_ctrl_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  write_fifo_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .AF_LEVEL   (AF_LEVEL)
  ) dut (
    .w_clk_in     (clk),
    .w_reset_n_in (rst_n),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.w_request_in  = 1'b0;
    bus.r_ptr_gray_in = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.w_request_in  = 1'b1;
    bus.r_ptr_gray_in = '0;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.w_ptr_out !== 3'd0 || bus.w_ptr_gray_out !== 3'd0) begin
      failures++;
      $display("FAIL reset_ptrs: ptr=%0d gray=%0d expected 0/0", bus.w_ptr_out, bus.w_ptr_gray_out);
    end
    checks++;
    if (bus.ctrl_full_out !== 1'b0 || bus.ctrl_almost_full_out !== 1'b0 || bus.ctrl_overflow_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: full=%b af=%b ovf=%b expected 0/0/0",
               bus.ctrl_full_out, bus.ctrl_almost_full_out, bus.ctrl_overflow_out);
    end
    checks++;
    if (bus.w_en_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_wen: w_en=%b expected 0 while in reset", bus.w_en_out);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.w_ptr_out !== 3'd1 || bus.w_ptr_gray_out !== 3'd1) begin
      failures++;
      $display("FAIL first_write: ptr=%0d gray=%0d expected 1/1", bus.w_ptr_out, bus.w_ptr_gray_out);
    end
    bus.w_request_in = 1'b0;
  endtask

  task automatic test_fill();
    logic [ADDR_WIDTH-1:0] exp_gray [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
    do_reset();
    bus.w_request_in = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++;
      if (bus.w_ptr_out !== 3'(i) || bus.w_ptr_gray_out !== exp_gray[i] || bus.ctrl_full_out !== (i == 7)) begin
        failures++;
        $display("FAIL fill_%0d: ptr=%0d gray=%0d full=%b expected %0d/%0d/%b",
                 i, bus.w_ptr_out, bus.w_ptr_gray_out, bus.ctrl_full_out, i, exp_gray[i], (i == 7));
      end
    end
  endtask

  task automatic test_overflow();
    checks++;
    if (bus.w_en_out !== 1'b0 || bus.ctrl_overflow_out !== 1'b0) begin
      failures++;
      $display("FAIL ovf_pre: w_en=%b ovf=%b expected 0/0", bus.w_en_out, bus.ctrl_overflow_out);
    end
    tick();
    checks++;
    if (bus.w_ptr_out !== 3'd7 || bus.ctrl_overflow_out !== 1'b1 || bus.ctrl_full_out !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: ptr=%0d ovf=%b full=%b expected 7/1/1",
               bus.w_ptr_out, bus.ctrl_overflow_out, bus.ctrl_full_out);
    end
    bus.w_request_in = 1'b0;
    tick();
    checks++;
    if (bus.w_ptr_out !== 3'd7 || bus.ctrl_overflow_out !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky: ptr=%0d ovf=%b expected 7/1", bus.w_ptr_out, bus.ctrl_overflow_out);
    end
  endtask

  task automatic test_drain_wrap();
    logic exp_full [3] = '{1'b1, 1'b1, 1'b0};
    bus.r_ptr_gray_in = 3'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.ctrl_full_out !== exp_full[i]) begin
        failures++;
        $display("FAIL drain_edge%0d: full=%b expected %b", i + 1, bus.ctrl_full_out, exp_full[i]);
      end
    end
    bus.w_request_in = 1'b1;
    #1;
    checks++;
    if (bus.w_en_out !== 1'b1) begin
      failures++;
      $display("FAIL drain_wen: w_en=%b expected 1", bus.w_en_out);
    end
    tick();
    checks++;
    if (bus.w_ptr_out !== 3'd0 || bus.w_ptr_gray_out !== 3'd0 || bus.ctrl_full_out !== 1'b1) begin
      failures++;
      $display("FAIL wrap: ptr=%0d gray=%0d full=%b expected 0/0/1",
               bus.w_ptr_out, bus.w_ptr_gray_out, bus.ctrl_full_out);
    end
    bus.w_request_in = 1'b0;
  endtask

  // Read side moves to 5: full clears after sync, then writes run up to ptr 4 and refill.
  task automatic test_async_reset();
    bus.r_ptr_gray_in = 3'b111;
    bus.w_request_in  = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (bus.w_ptr_out !== 3'd4 || bus.ctrl_full_out !== 1'b1 || bus.ctrl_overflow_out !== 1'b1) begin
      failures++;
      $display("FAIL midburst: ptr=%0d full=%b ovf=%b expected 4/1/1",
               bus.w_ptr_out, bus.ctrl_full_out, bus.ctrl_overflow_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.w_ptr_out !== 3'd0 || bus.w_ptr_gray_out !== 3'd0 || bus.w_en_out !== 1'b0) begin
      failures++;
      $display("FAIL async_rst_ptr: ptr=%0d gray=%0d w_en=%b expected 0/0/0",
               bus.w_ptr_out, bus.w_ptr_gray_out, bus.w_en_out);
    end
    checks++;
    if (bus.ctrl_full_out !== 1'b0 || bus.ctrl_overflow_out !== 1'b0 || bus.ctrl_almost_full_out !== 1'b0) begin
      failures++;
      $display("FAIL async_rst_flags: full=%b ovf=%b af=%b expected 0/0/0",
               bus.ctrl_full_out, bus.ctrl_overflow_out, bus.ctrl_almost_full_out);
    end
    bus.w_request_in = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_almost_full();
    do_reset();
    bus.w_request_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.w_request_in = 1'b0;
    tick();
    checks++;
    if (bus.w_ptr_out !== 3'd5 || bus.ctrl_almost_full_out !== 1'b0) begin
      failures++;
      $display("FAIL af_at5: ptr=%0d af=%b expected 5/0", bus.w_ptr_out, bus.ctrl_almost_full_out);
    end
    bus.w_request_in = 1'b1;
    tick();
    bus.w_request_in = 1'b0;
    checks++;
    if (bus.w_ptr_out !== 3'd6 || bus.ctrl_almost_full_out !== 1'b0) begin
      failures++;
      $display("FAIL af_6th_edge: ptr=%0d af=%b expected 6/0", bus.w_ptr_out, bus.ctrl_almost_full_out);
    end
    tick();
    checks++;
    if (bus.ctrl_almost_full_out !== AF_EN || bus.ctrl_full_out !== 1'b0) begin
      failures++;
      $display("FAIL af_at6: af=%b full=%b expected %b/0", bus.ctrl_almost_full_out, bus.ctrl_full_out, AF_EN);
    end
  endtask

  initial begin
    bus.w_request_in  = 1'b0;
    bus.r_ptr_gray_in = '0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain_wrap();
    test_async_reset();
    test_almost_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
